// File: rtl/eth_rx_frame_ctrl.sv
// rtl/eth_rx_frame_ctrl.sv - GMII receive frame sequencer with FCS strip and frame statistics
module eth_rx_frame_ctrl #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [7:0]       gmii_rxd,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    output logic             crc_init,
    output logic             crc_en,
    output logic [7:0]       crc_data,
    input  logic             crc_ok,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic [CNT_W-1:0] frame_ok_cnt,
    output logic [CNT_W-1:0] frame_err_cnt,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_PAYLOAD,
        S_CHECK,
        S_DROP
    } state_t;

    localparam logic [11:0] MIN_L = 12'(MIN_LEN);
    localparam logic [11:0] MAX_L = 12'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t          state_q;
    logic [2:0]      pre_cnt_q;
    logic [11:0]     byte_cnt_q;
    logic            err_q;
    logic [3:0][7:0] dl_q;        // dl_q[3] is the oldest byte once the line is full
    logic [2:0]      dl_cnt_q;
    logic [7:0]      hold_q;
    logic            hold_vld_q;
    logic [7:0]      tdata_q;
    logic            tvalid_q;
    logic            tlast_q;
    logic            tuser_q;
    logic [CNT_W-1:0] ok_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic            frame_bad_d;

    // CRC strobes follow the live GMII byte so the checker sees it in the same cycle
    always_comb begin
        crc_init    = (state_q == S_PREAMBLE) && gmii_rx_dv && (gmii_rxd == 8'hD5);
        crc_en      = (state_q == S_PAYLOAD) && gmii_rx_dv;
        crc_data    = crc_en ? gmii_rxd : 8'h00;
        frame_bad_d = !crc_ok || (byte_cnt_q < MIN_L) || (byte_cnt_q > MAX_L) || err_q;
    end

    // Frame sequencer: preamble hunt, FCS delay line, end-of-frame verdict and statistics
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= S_IDLE;
            pre_cnt_q  <= 3'd0;
            byte_cnt_q <= 12'd0;
            err_q      <= 1'b0;
            dl_q       <= '0;
            dl_cnt_q   <= 3'd0;
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
            tdata_q    <= 8'h00;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            ok_cnt_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == 8'h55) begin
                            state_q   <= S_PREAMBLE;
                            pre_cnt_q <= 3'd1;
                        end else begin
                            state_q <= S_DROP;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state_q <= S_IDLE;
                    end else if (gmii_rxd == 8'h55) begin
                        if (pre_cnt_q == 3'd7) state_q <= S_DROP;
                        else pre_cnt_q <= pre_cnt_q + 3'd1;
                    end else if (gmii_rxd == 8'hD5) begin
                        state_q <= S_PAYLOAD;
                    end else begin
                        state_q <= S_DROP;
                    end
                end
                S_PAYLOAD: begin
                    if (gmii_rx_dv) begin
                        if (byte_cnt_q != 12'hFFF) byte_cnt_q <= byte_cnt_q + 12'd1;
                        if (gmii_rx_er) err_q <= 1'b1;
                        dl_q <= {dl_q[2:0], gmii_rxd};
                        if (dl_cnt_q == 3'd4) begin
                            // Four newer bytes are queued behind it, so the oldest cannot be FCS
                            hold_q     <= dl_q[3];
                            hold_vld_q <= 1'b1;
                            if (hold_vld_q) begin
                                tdata_q  <= hold_q;
                                tvalid_q <= 1'b1;
                            end
                        end else begin
                            dl_cnt_q <= dl_cnt_q + 3'd1;
                        end
                    end else begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (hold_vld_q) begin
                        tdata_q  <= hold_q;
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b1;
                        tuser_q  <= frame_bad_d;
                    end
                    if (frame_bad_d) begin
                        if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + CNT_ONE;
                    end else begin
                        if (!(&ok_cnt_q)) ok_cnt_q <= ok_cnt_q + CNT_ONE;
                    end
                    dl_cnt_q   <= 3'd0;
                    hold_vld_q <= 1'b0;
                    byte_cnt_q <= 12'd0;
                    err_q      <= 1'b0;
                    state_q    <= gmii_rx_dv ? S_DROP : S_IDLE;
                end
                S_DROP: begin
                    if (!gmii_rx_dv) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign frame_ok_cnt  = ok_cnt_q;
    assign frame_err_cnt = err_cnt_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// tb/tb_eth_rx_frame_ctrl.sv - directed self-checking bench for eth_rx_frame_ctrl
module tb_eth_rx_frame_ctrl;

    localparam int CNT_W = 3;
    localparam int CNT_MAX = 7;

    logic             aclk = 1'b0;
    logic             areset;
    logic [7:0]       gmii_rxd;
    logic             gmii_rx_dv;
    logic             gmii_rx_er;
    logic             crc_init;
    logic             crc_en;
    logic [7:0]       crc_data;
    logic             crc_ok;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tuser;
    logic [CNT_W-1:0] frame_ok_cnt;
    logic [CNT_W-1:0] frame_err_cnt;
    logic             busy;

    eth_rx_frame_ctrl #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(CNT_W)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .gmii_rxd      (gmii_rxd),
        .gmii_rx_dv    (gmii_rx_dv),
        .gmii_rx_er    (gmii_rx_er),
        .crc_init      (crc_init),
        .crc_en        (crc_en),
        .crc_data      (crc_data),
        .crc_ok        (crc_ok),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;
    int exp_ok  = 0;
    int exp_err = 0;

    int n_init, n_en, n_beats, n_data_err, n_last, last_idx, n_viol;
    logic last_user;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_mon();
        n_init = 0; n_en = 0; n_beats = 0; n_data_err = 0;
        n_last = 0; last_idx = -1; n_viol = 0; last_user = 1'b0;
    endtask

    // Frame bytes are i mod 256, so beat k must carry k mod 256
    always @(negedge aclk) begin
        if (!areset) begin
            if (crc_init) n_init++;
            if (crc_en) begin
                n_en++;
                if (crc_data !== gmii_rxd) n_data_err++;
            end
            if (m_axis_tvalid) begin
                if (m_axis_tdata !== n_beats[7:0]) n_data_err++;
                if (m_axis_tlast) begin
                    n_last++;
                    last_idx  = n_beats;
                    last_user = m_axis_tuser;
                end
                n_beats++;
            end else if (m_axis_tlast || m_axis_tuser) begin
                n_viol++;
            end
        end
    end

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        @(posedge aclk);
        #1;
        gmii_rx_dv = dv;
        gmii_rxd   = d;
        gmii_rx_er = er;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic bump(input logic fbad);
        if (fbad) exp_err = (exp_err == CNT_MAX) ? CNT_MAX : exp_err + 1;
        else      exp_ok  = (exp_ok  == CNT_MAX) ? CNT_MAX : exp_ok + 1;
    endtask

    task automatic run_frame(input string tag, input int npre, input int nbytes, input int er_at, input logic ok);
        int   beats;
        logic fbad;
        clear_mon();
        crc_ok = ok;
        for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < nbytes; i++) drive(1'b1, 8'(i), (i == er_at));
        idle(12);
        beats = (nbytes > 4) ? nbytes - 4 : 0;
        fbad  = !ok || (nbytes < 64) || (nbytes > 1518) || (er_at >= 0);
        bump(fbad);
        check_eq({tag, ".init"}, n_init, 1);
        check_eq({tag, ".en"}, n_en, nbytes);
        check_eq({tag, ".beats"}, n_beats, beats);
        check_eq({tag, ".data"}, n_data_err, 0);
        check_eq({tag, ".nlast"}, n_last, (beats > 0) ? 1 : 0);
        if (beats > 0) begin
            check_eq({tag, ".lastidx"}, last_idx, beats - 1);
            check_eq({tag, ".tuser"}, {31'd0, last_user}, {31'd0, fbad});
        end
        check_eq({tag, ".viol"}, n_viol, 0);
        check_eq({tag, ".okcnt"}, {29'd0, frame_ok_cnt}, exp_ok);
        check_eq({tag, ".errcnt"}, {29'd0, frame_err_cnt}, exp_err);
        check_eq({tag, ".busy"}, {31'd0, busy}, 0);
    endtask

    task automatic run_junk(input string tag, input int nstart55, input logic [7:0] brk, input int ntail);
        clear_mon();
        crc_ok = 1'b1;
        for (int i = 0; i < nstart55; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, brk, 1'b0);
        for (int i = 0; i < ntail; i++) drive(1'b1, 8'(i), 1'b0);
        check_eq({tag, ".busy_hi"}, {31'd0, busy}, 1);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check_eq({tag, ".busy_lo"}, {31'd0, busy}, 0);
        idle(10);
        check_eq({tag, ".init"}, n_init, 0);
        check_eq({tag, ".en"}, n_en, 0);
        check_eq({tag, ".beats"}, n_beats, 0);
        check_eq({tag, ".okcnt"}, {29'd0, frame_ok_cnt}, exp_ok);
        check_eq({tag, ".errcnt"}, {29'd0, frame_err_cnt}, exp_err);
    endtask

    initial begin
        areset     = 1'b1;
        gmii_rxd   = 8'h00;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        crc_ok     = 1'b0;
        clear_mon();
        #1;
        check_eq("rst.tvalid", {31'd0, m_axis_tvalid}, 0);
        check_eq("rst.busy", {31'd0, busy}, 0);
        check_eq("rst.okcnt", {29'd0, frame_ok_cnt}, 0);
        check_eq("rst.errcnt", {29'd0, frame_err_cnt}, 0);
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        idle(2);

        run_frame("good64", 7, 64, -1, 1'b1);
        run_frame("crcbad", 7, 64, -1, 1'b0);
        run_frame("runt40", 7, 40, -1, 1'b1);
        run_frame("over1519", 7, 1519, -1, 1'b1);
        run_junk("pre_aa", 2, 8'hAA, 60);
        run_junk("pre_8x55", 8, 8'hD5, 64);
        run_frame("rxer20", 7, 64, 20, 1'b1);
        run_frame("pre1", 1, 64, -1, 1'b1);
        run_frame("max1518", 7, 1518, -1, 1'b1);
        run_frame("len63", 7, 63, -1, 1'b1);
        run_frame("len3", 7, 3, -1, 1'b1);
        run_frame("len4", 7, 4, -1, 1'b1);
        run_frame("len5", 7, 5, -1, 1'b1);
        run_frame("len2sat", 7, 2, -1, 1'b1);

        // Reset while payload byte 30 is on the wire
        clear_mon();
        crc_ok = 1'b1;
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) drive(1'b1, 8'(i), 1'b0);
        @(posedge aclk);
        #2;
        check_eq("abort.pre_tvalid", {31'd0, m_axis_tvalid}, 1);
        areset = 1'b1;
        #1;
        check_eq("abort.tvalid", {31'd0, m_axis_tvalid}, 0);
        check_eq("abort.busy", {31'd0, busy}, 0);
        check_eq("abort.okcnt", {29'd0, frame_ok_cnt}, 0);
        check_eq("abort.errcnt", {29'd0, frame_err_cnt}, 0);
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        idle(4);
        check_eq("abort.nlast", n_last, 0);
        exp_ok  = 0;
        exp_err = 0;
        run_frame("after_rst", 7, 64, -1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_ctrl.md
Name: eth_rx_frame_ctrl

Overview:
Receive-side frame sequencer for the GMII byte stream. Hunts preamble/SFD, drives the init and enable strobes of the external CRC-32 checker, and strips the 4-byte FCS through a delay line. Emits payload as a byte stream with end-of-frame and error flags, and keeps good/bad frame counters. Sits between the GMII RX pins and the MAC RX FIFO, owning the CRC checker instance.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS inclusive)
MAX_LEN, 1518, maximum legal frame length in bytes (DA through FCS inclusive)
CNT_W, 16, width of statistics counters

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  asynchronous, active-high reset
gmii_rxd  in  8  receive byte
gmii_rx_dv  in  1  receive data valid
gmii_rx_er  in  1  receive error
crc_init  out  1  one-cycle pulse: preset CRC register to 0xFFFFFFFF
crc_en  out  1  CRC checker consumes crc_data this cycle
crc_data  out  8  byte to CRC checker; equals gmii_rxd
crc_ok  in  1  checker residue matches (FCS good); stable from cycle after last crc_en until next crc_init
m_axis_tdata  out  8  payload byte (FCS removed)
m_axis_tvalid  out  1  beat valid; no backpressure, one cycle per beat
m_axis_tlast  out  1  last payload byte of frame
m_axis_tuser  out  1  frame bad; valid only with tlast
frame_ok_cnt  out  CNT_W  good frames, saturating
frame_err_cnt  out  CNT_W  bad frames, saturating
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; delay line and hold register empty; byte_cnt 0; err flag 0. Reset mid-frame aborts the frame with no output beat and no counter change.
- States: IDLE, PREAMBLE, PAYLOAD, CHECK, DROP. All transitions evaluate on sampled gmii_rx_dv/gmii_rxd.
- IDLE: dv=1 and rxd=0x55 -> PREAMBLE (pre_cnt=1). dv=1 and any other byte -> DROP.
- PREAMBLE: dv=0 -> IDLE. rxd=0x55 with pre_cnt<7 -> stay, pre_cnt++. rxd=0x55 with pre_cnt=7 -> DROP. rxd=0xD5 -> PAYLOAD, with crc_init=1 combinationally in that cycle. Any other byte -> DROP. 1..7 preamble bytes are accepted.
- PAYLOAD: each dv=1 cycle drives crc_en=1 and crc_data=gmii_rxd (combinational).
  - byte_cnt increments, saturating at 4095.
  - gmii_rx_er=1 sets the sticky err flag.
  - Byte is pushed into a 4-deep delay line. When the line is full, its oldest byte moves to a 1-byte hold register.
  - If hold was already occupied, the old hold byte is emitted on the next edge (tvalid=1, tlast=0, tuser=0).
  - Byte n appears on m_axis the cycle after byte n+5 is sampled.
- dv=0 in PAYLOAD -> CHECK, lasting exactly one cycle.
  - Compute bad = !crc_ok | byte_cnt<MIN_LEN | byte_cnt>MAX_LEN | err flag.
  - At the edge ending CHECK, if hold is occupied: emit hold byte with tlast=1, tuser=bad.
  - Frames of 4 or fewer bytes produce no beat; they are always bad.
  - Increment frame_ok_cnt if !bad, else frame_err_cnt.
  - Clear delay line, hold, byte_cnt and err flag.
  - Next state: IDLE if dv=0, DROP if dv=1.
- DROP: no strobes, no beats, no counter change. dv=0 -> IDLE.
- crc_en never asserts outside PAYLOAD. crc_init asserts at most once per frame.
- tvalid is high for one cycle per beat and never two beats in one cycle. tlast/tuser are 0 when tvalid=0.
- Counters saturate at all-ones and do not wrap.
- Back-to-back frames: the minimum 12-byte IFG guarantees CHECK completes before the next preamble.

Test Plan:
- 7x0x55, 0xD5, 60 bytes 0x00..0x3B, 4 FCS bytes, crc_ok=1 -> crc_init once; 64 crc_en cycles; 60 beats 0x00..0x3B; tlast on 0x3B with tuser=0; frame_ok_cnt=1.
- Same frame with crc_ok=0 -> 60 beats; tlast on 0x3B with tuser=1; frame_err_cnt=1; frame_ok_cnt unchanged.
- Runt: 40 bytes after SFD, crc_ok=1 -> 36 beats, tuser=1 on last. Oversize: 1519 bytes -> 1515 beats, tuser=1 on last.
- Preamble 0x55,0x55,0xAA,... and separately 8x0x55 then 0xD5 -> no crc_init, no crc_en, no beats, counters unchanged, busy drops when dv falls.
- gmii_rx_er pulsed at payload byte 20 of a 64-byte good-CRC frame -> tuser=1 on last beat; frame_err_cnt++.
- areset asserted at payload byte 30 -> tvalid and busy go 0 immediately; no tlast; counters 0. A following good frame passes cleanly.
